// File: rtl/cmd_frame_receiver_if.sv
// Command-frame receiver bundle: one-wire line and enable towards the receiver, frame and status back.
// master = line driver / host side, slave = receiver.
interface cmd_frame_receiver_if #(
    parameter int FRAME_BITS = 8
);
    logic                  bus;
    logic                  en_cmd_recieve;
    logic [FRAME_BITS-1:0] frame;
    logic                  done_recieving;
    logic                  busy;
    logic                  timeout_err;
    logic                  parity_err;

    modport master (
        output bus, en_cmd_recieve,
        input  frame, done_recieving, busy, timeout_err, parity_err
    );

    modport slave (
        input  bus, en_cmd_recieve,
        output frame, done_recieving, busy, timeout_err, parity_err
    );
endinterface

// File: rtl/cmd_frame_receiver.sv
// Purpose: one-wire slot-coded frame receiver (LSB first); CMD_RX_PARITY_EN adds a trailing odd-parity slot.
// Latency: done_recieving N*BIT_PERIOD+3 clk after the first bus fall (2 sync + edge detect + DONE register).
// Backpressure: none; the line cannot be stalled, so frames are published in a one-cycle DONE pulse.
module cmd_frame_receiver #(
    parameter int FRAME_BITS    = 8,
    parameter int BIT_PERIOD    = 71,
    parameter int SAMPLE_OFFSET = 30,
    parameter int TIMEOUT       = 1000
) (
    input logic                 clk,
    input logic                 rst_n,
    cmd_frame_receiver_if.slave rx
);
`ifdef CMD_RX_PARITY_EN
    localparam int NSLOTS = FRAME_BITS + 1;
`else
    localparam int NSLOTS = FRAME_BITS;
`endif
    localparam int SCW = $clog2(BIT_PERIOD);
    localparam int BCW = $clog2(NSLOTS + 1);
    localparam int ICW = $clog2(TIMEOUT);

    localparam logic [SCW-1:0] SAMPLE_AT = SCW'(SAMPLE_OFFSET);
    localparam logic [SCW-1:0] SLOT_LAST = SCW'(BIT_PERIOD - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(NSLOTS - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SLOT, DONE} state_e;

    state_e             state_q, state_d;
    logic               bus_meta_q, bus_s_q, bus_prev_q;
    logic [SCW-1:0]     slot_cnt_q, slot_cnt_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [ICW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [NSLOTS-1:0]  shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic               timeout_q, timeout_d;
    logic               restart_q, restart_d;
    logic               slot_start;
    logic               done_vld;

    assign slot_start = bus_prev_q & ~bus_s_q;
    assign done_vld   = (state_q == DONE) & rx.en_cmd_recieve;

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        shreg_d    = shreg_q;
        frame_d    = frame_q;
        timeout_d  = 1'b0;
        restart_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                state_d    = ARMED;
            end
            ARMED: begin
                if (slot_start) begin
                    state_d    = SLOT;
                    slot_cnt_d = '0;
                    idle_cnt_d = '0;
                end else if (bit_cnt_q != '0) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        timeout_d  = 1'b1;
                        bit_cnt_d  = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + ICW'(1);
                    end
                end
            end
            SLOT: begin
                slot_cnt_d = slot_cnt_q + SCW'(1);
                if (slot_cnt_q == SAMPLE_AT) begin
                    shreg_d = NSLOTS'({bus_s_q, shreg_q} >> 1);
                end
                if (slot_cnt_q == SLOT_LAST) begin
                    bit_cnt_d  = bit_cnt_q + BCW'(1);
                    idle_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = DONE;
                        restart_d = slot_start;
                    end else if (slot_start) begin
                        slot_cnt_d = '0;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            DONE: begin
                frame_d   = shreg_q[FRAME_BITS-1:0];
                bit_cnt_d = '0;
                // A back-to-back frame already started one cycle ago, so its slot is one cycle in.
                if (restart_q) begin
                    state_d    = SLOT;
                    slot_cnt_d = SCW'(1);
                end else begin
                    state_d = ARMED;
                end
            end
        endcase

        if (!rx.en_cmd_recieve) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            idle_cnt_d = '0;
            frame_d    = frame_q;
            timeout_d  = 1'b0;
            restart_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_meta_q <= 1'b1;
            bus_s_q    <= 1'b1;
            bus_prev_q <= 1'b1;
            state_q    <= IDLE;
            slot_cnt_q <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            shreg_q    <= '0;
            frame_q    <= '0;
            timeout_q  <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            bus_meta_q <= rx.bus;
            bus_s_q    <= bus_meta_q;
            bus_prev_q <= bus_s_q;
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shreg_q    <= shreg_d;
            frame_q    <= frame_d;
            timeout_q  <= timeout_d;
            restart_q  <= restart_d;
        end
    end

    assign rx.frame          = done_vld ? shreg_q[FRAME_BITS-1:0] : frame_q;
    assign rx.done_recieving = done_vld;
    assign rx.busy           = (state_q == SLOT) | ((state_q == ARMED) & (bit_cnt_q != '0));
    assign rx.timeout_err    = timeout_q;

`ifdef CMD_RX_PARITY_EN
    assign rx.parity_err = done_vld & ~(^shreg_q);
`else
    assign rx.parity_err = 1'b0;
`endif
endmodule
